// File: rtl/msrv32_mem_arbiter.sv
// msrv32_mem_arbiter
// Shares one AHB-Lite slave port between the msrv32 instruction-fetch path
// and the load/store path. Each access runs as an address phase followed by
// a data phase; ready/data/error go back to whichever requester owns it.
// Data requests win arbitration, but a streak counter forces a fetch grant
// after MAX_DATA_STREAK consecutive data grants while a fetch is waiting.
//
// Ports
//   clock, rst_in          rising-edge clock, async active-high reset
//   i_req_in/i_addr_in     fetch request and address
//   i_rdata_out/i_ready_out/i_err_out   fetch response
//   d_req_in/d_wr_in/d_addr_in/d_wdata_in/d_mask_in   load/store request
//   d_rdata_out/d_ready_out/d_err_out   load/store response
//   haddr_out/htrans_out/hwrite_out/hsize_out/hwdata_out   AHB master side
//   hrdata_in/hready_in/hresp_in        AHB slave response
//   owner_out              current/last owner, 0 = fetch, 1 = data
module msrv32_mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clock,
  input  logic        rst_in,

  input  logic        i_req_in,
  input  logic [31:0] i_addr_in,
  output logic [31:0] i_rdata_out,
  output logic        i_ready_out,
  output logic        i_err_out,

  input  logic        d_req_in,
  input  logic        d_wr_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_mask_in,
  output logic [31:0] d_rdata_out,
  output logic        d_ready_out,
  output logic        d_err_out,

  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in,

  output logic        owner_out
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic                owner_q;
  logic [ADDR_W-1:0]   haddr_q;
  logic [1:0]          htrans_q;
  logic                hwrite_q;
  logic [2:0]          hsize_q;
  logic [DATA_W-1:0]   hwdata_q;
  logic [STREAK_W-1:0] streak_q;

  logic                grant_d_c;
  logic                grant_i_c;
  logic                take_grant_c;

  // Narrow writes pick their AHB size from the byte-lane mask; anything
  // irregular falls back to a word transfer.
  function automatic logic [2:0] mask_to_hsize(input logic [3:0] mask);
    logic [2:0] size;
    case (mask)
      4'b1111:                            size = HSIZE_WORD;
      4'b0011, 4'b1100:                   size = HSIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = HSIZE_BYTE;
      default:                            size = HSIZE_WORD;
    endcase
    return size;
  endfunction

  // Arbitration: data first, unless a waiting fetch has been passed over
  // MAX_DATA_STREAK times in a row.
  always_comb begin
    grant_d_c    = d_req_in && !(i_req_in && (streak_q == STREAK_MAX));
    grant_i_c    = !grant_d_c && i_req_in;
    take_grant_c = (state_q == ST_IDLE) && (grant_d_c || grant_i_c);
  end

  // State register.
  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_d_c || grant_i_c) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (hready_in) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (hready_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response outputs: completion is signalled in the same cycle the slave
  // finishes the data phase, so these decode state, owner and hready_in.
  always_comb begin
    i_ready_out = 1'b0;
    d_ready_out = 1'b0;
    i_err_out   = 1'b0;
    d_err_out   = 1'b0;
    if ((state_q == ST_DATA) && hready_in) begin
      if (owner_q) begin
        d_ready_out = 1'b1;
        d_err_out   = hresp_in;
      end else begin
        i_ready_out = 1'b1;
        i_err_out   = hresp_in;
      end
    end
  end

  // Address/control and write-data capture at grant; held until next grant
  // so the bus stays stable through wait states even if requests change.
  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      owner_q  <= 1'b0;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= HSIZE_WORD;
      hwdata_q <= '0;
    end else begin
      if (take_grant_c) begin
        owner_q  <= grant_d_c;
        htrans_q <= HTRANS_NONSEQ;
        if (grant_d_c) begin
          haddr_q  <= d_addr_in;
          hwrite_q <= d_wr_in;
          hsize_q  <= d_wr_in ? mask_to_hsize(d_mask_in) : HSIZE_WORD;
          hwdata_q <= d_wdata_in;
        end else begin
          haddr_q  <= i_addr_in;
          hwrite_q <= 1'b0;
          hsize_q  <= HSIZE_WORD;
          hwdata_q <= '0;
        end
      end else if ((state_q == ST_ADDR) && hready_in) begin
        htrans_q <= HTRANS_IDLE;
      end
    end
  end

  // Data-grant streak: counts data grants that bypassed a waiting fetch.
  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      streak_q <= '0;
    end else if (take_grant_c) begin
      if (grant_d_c && i_req_in) begin
        if (streak_q < STREAK_MAX) begin
          streak_q <= streak_q + STREAK_W'(1);
        end
      end else begin
        streak_q <= '0;
      end
    end
  end

  assign owner_out   = owner_q;
  assign haddr_out   = haddr_q;
  assign htrans_out  = htrans_q;
  assign hwrite_out  = hwrite_q;
  assign hsize_out   = hsize_q;
  assign hwdata_out  = hwdata_q;

  // Read data goes straight through to both requesters.
  assign i_rdata_out = hrdata_in;
  assign d_rdata_out = hrdata_in;

endmodule

// File: tb/tb_msrv32_mem_arbiter.sv
// Directed bench for msrv32_mem_arbiter: a table of single transactions
// followed by hand-written arbitration, wait-state and reset sequences.
module tb_msrv32_mem_arbiter;

  logic        clock;
  logic        rst_in;
  logic        i_req_in;
  logic [31:0] i_addr_in;
  logic [31:0] i_rdata_out;
  logic        i_ready_out;
  logic        i_err_out;
  logic        d_req_in;
  logic        d_wr_in;
  logic [31:0] d_addr_in;
  logic [31:0] d_wdata_in;
  logic [3:0]  d_mask_in;
  logic [31:0] d_rdata_out;
  logic        d_ready_out;
  logic        d_err_out;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [31:0] hwdata_out;
  logic [31:0] hrdata_in;
  logic        hready_in;
  logic        hresp_in;
  logic        owner_out;

  msrv32_mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clock       (clock),
    .rst_in      (rst_in),
    .i_req_in    (i_req_in),
    .i_addr_in   (i_addr_in),
    .i_rdata_out (i_rdata_out),
    .i_ready_out (i_ready_out),
    .i_err_out   (i_err_out),
    .d_req_in    (d_req_in),
    .d_wr_in     (d_wr_in),
    .d_addr_in   (d_addr_in),
    .d_wdata_in  (d_wdata_in),
    .d_mask_in   (d_mask_in),
    .d_rdata_out (d_rdata_out),
    .d_ready_out (d_ready_out),
    .d_err_out   (d_err_out),
    .haddr_out   (haddr_out),
    .htrans_out  (htrans_out),
    .hwrite_out  (hwrite_out),
    .hsize_out   (hsize_out),
    .hwdata_out  (hwdata_out),
    .hrdata_in   (hrdata_in),
    .hready_in   (hready_in),
    .hresp_in    (hresp_in),
    .owner_out   (owner_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_data;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        resp;
    logic [2:0]  exp_size;
  } vec_t;

  localparam int NVEC = 10;
  vec_t  vecs [NVEC];
  int    n_vec;
  int    n_err;
  string tag;
  int    exp_seq [6] = '{1, 1, 1, 1, 0, 1};
  int    got_seq [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%08h, want 0x%08h", tag, name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One complete zero-wait transaction, checked at each phase.
  task automatic run_txn(input vec_t v);
    step();
    hready_in = 1'b1;
    hresp_in  = 1'b0;
    if (v.is_data) begin
      d_req_in   = 1'b1;
      d_wr_in    = v.wr;
      d_addr_in  = v.addr;
      d_wdata_in = v.wdata;
      d_mask_in  = v.mask;
    end else begin
      i_req_in  = 1'b1;
      i_addr_in = v.addr;
    end
    #1;
    chk("idle_htrans", 32'(htrans_out), 32'h0);
    step();
    #1;
    chk("addr_htrans", 32'(htrans_out), 32'h2);
    chk("addr_haddr",  haddr_out, v.addr);
    chk("addr_hwrite", 32'(hwrite_out), 32'(v.is_data & v.wr));
    chk("addr_hsize",  32'(hsize_out), 32'(v.exp_size));
    chk("addr_owner",  32'(owner_out), 32'(v.is_data));
    step();
    hrdata_in = v.rdata;
    hresp_in  = v.resp;
    #1;
    chk("data_htrans", 32'(htrans_out), 32'h0);
    if (v.is_data) begin
      chk("data_d_ready", 32'(d_ready_out), 32'h1);
      chk("data_i_ready", 32'(i_ready_out), 32'h0);
      chk("data_d_rdata", d_rdata_out, v.rdata);
      chk("data_d_err",   32'(d_err_out), 32'(v.resp));
      chk("data_i_err",   32'(i_err_out), 32'h0);
      if (v.wr) chk("data_hwdata", hwdata_out, v.wdata);
    end else begin
      chk("data_i_ready", 32'(i_ready_out), 32'h1);
      chk("data_d_ready", 32'(d_ready_out), 32'h0);
      chk("data_i_rdata", i_rdata_out, v.rdata);
      chk("data_i_err",   32'(i_err_out), 32'(v.resp));
      chk("data_d_err",   32'(d_err_out), 32'h0);
    end
    step();
    i_req_in = 1'b0;
    d_req_in = 1'b0;
    hresp_in = 1'b0;
    #1;
    chk("done_i_ready", 32'(i_ready_out), 32'h0);
    chk("done_d_ready", 32'(d_ready_out), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_done;
    n_vec = 0;
    n_err = 0;
    tag   = "reset";

    //          data  wr    addr          wdata         mask     rdata         resp  size
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_0013, 1'b0, 3'b010};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,        4'b0000, 32'hDEAD_BEEF, 1'b0, 3'b010};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_2004, 32'h1122_3344, 4'b1111, 32'h0,        1'b0, 3'b010};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_2002, 32'hAAAA_5555, 4'b1100, 32'h0,        1'b0, 3'b001};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_2010, 32'h0000_BEEF, 4'b0011, 32'h0,        1'b0, 3'b001};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_2022, 32'h0077_0000, 4'b0100, 32'h0,        1'b0, 3'b000};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_2033, 32'h9900_0000, 4'b1000, 32'h0,        1'b0, 3'b000};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_2040, 32'h1234_5678, 4'b0101, 32'h0,        1'b0, 3'b010};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_2050, 32'h0,        4'b0000, 32'h0BAD_0BAD, 1'b1, 3'b010};
    vecs[9] = '{1'b0, 1'b0, 32'h0000_0204, 32'h0,        4'b0000, 32'hFEED_F00D, 1'b1, 3'b010};

    rst_in     = 1'b1;
    i_req_in   = 1'b0;
    i_addr_in  = '0;
    d_req_in   = 1'b0;
    d_wr_in    = 1'b0;
    d_addr_in  = '0;
    d_wdata_in = '0;
    d_mask_in  = '0;
    hrdata_in  = 32'h5A5A_A5A5;
    hready_in  = 1'b1;
    hresp_in   = 1'b0;

    // Reset values
    repeat (2) @(posedge clock);
    #2;
    chk("htrans",  32'(htrans_out), 32'h0);
    chk("haddr",   haddr_out, 32'h0);
    chk("hwrite",  32'(hwrite_out), 32'h0);
    chk("hsize",   32'(hsize_out), 32'h2);
    chk("hwdata",  hwdata_out, 32'h0);
    chk("owner",   32'(owner_out), 32'h0);
    chk("i_ready", 32'(i_ready_out), 32'h0);
    chk("d_ready", 32'(d_ready_out), 32'h0);
    chk("i_err",   32'(i_err_out), 32'h0);
    chk("d_err",   32'(d_err_out), 32'h0);
    chk("i_rdata", i_rdata_out, 32'h5A5A_A5A5);
    chk("d_rdata", d_rdata_out, 32'h5A5A_A5A5);
    step();
    rst_in = 1'b0;

    // Single transactions from the table
    for (int i = 0; i < NVEC; i++) begin
      tag = $sformatf("vec%0d", i);
      run_txn(vecs[i]);
    end

    // Simultaneous requests: data write wins, fetch address phase at N+4
    tag = "simul";
    step();
    i_req_in   = 1'b1;
    i_addr_in  = 32'h0000_0300;
    d_req_in   = 1'b1;
    d_wr_in    = 1'b1;
    d_addr_in  = 32'h0000_2002;
    d_wdata_in = 32'hABCD_0000;
    d_mask_in  = 4'b1100;
    hready_in  = 1'b1;
    hrdata_in  = 32'h0000_0093;
    #1;
    step(); #1;                                   // N+1
    chk("n1_haddr",  haddr_out, 32'h0000_2002);
    chk("n1_hwrite", 32'(hwrite_out), 32'h1);
    chk("n1_hsize",  32'(hsize_out), 32'h1);
    chk("n1_owner",  32'(owner_out), 32'h1);
    step(); #1;                                   // N+2
    chk("n2_d_ready", 32'(d_ready_out), 32'h1);
    chk("n2_i_ready", 32'(i_ready_out), 32'h0);
    step();                                       // N+3
    d_req_in = 1'b0;
    #1;
    chk("n3_htrans", 32'(htrans_out), 32'h0);
    step(); #1;                                   // N+4
    chk("n4_htrans", 32'(htrans_out), 32'h2);
    chk("n4_haddr",  haddr_out, 32'h0000_0300);
    chk("n4_owner",  32'(owner_out), 32'h0);
    step(); #1;                                   // N+5
    chk("n5_i_ready", 32'(i_ready_out), 32'h1);
    chk("n5_i_rdata", i_rdata_out, 32'h0000_0093);
    step();
    i_req_in = 1'b0;

    // Starvation bound: both held, expect D D D D I D
    tag = "starve";
    step();
    i_req_in  = 1'b1;
    i_addr_in = 32'h0000_0400;
    d_req_in  = 1'b1;
    d_wr_in   = 1'b0;
    d_addr_in = 32'h0000_4000;
    hready_in = 1'b1;
    n_done = 0;
    for (int c = 0; c < 60 && n_done < 6; c++) begin
      #1;
      if (d_ready_out && i_ready_out) begin
        chk("both_ready", 32'h1, 32'h0 | 32'(i_ready_out & 1'b0));
      end
      if (d_ready_out) begin
        got_seq[n_done] = 1;
        n_done++;
      end else if (i_ready_out) begin
        got_seq[n_done] = 0;
        n_done++;
      end
      step();
    end
    i_req_in = 1'b0;
    d_req_in = 1'b0;
    chk("completions", 32'(n_done), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < n_done) chk($sformatf("order%0d", k), 32'(got_seq[k]), 32'(exp_seq[k]));
    end
    repeat (3) step();

    // Wait states: 2 in ADDR, 3 in DATA; request dropped after grant
    tag = "wait";
    step();
    d_req_in   = 1'b1;
    d_wr_in    = 1'b1;
    d_addr_in  = 32'h0000_3000;
    d_wdata_in = 32'hCAFE_F00D;
    d_mask_in  = 4'b1111;
    hready_in  = 1'b1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      step();
      hready_in  = (k == 3 || k == 7 || k == 8);
      d_wdata_in = 32'hBAD0_0000 | 32'(k);
      if (k == 2) d_req_in = 1'b0;
      #1;
      chk($sformatf("k%0d_haddr", k),   haddr_out, 32'h0000_3000);
      chk($sformatf("k%0d_hwdata", k),  hwdata_out, 32'hCAFE_F00D);
      chk($sformatf("k%0d_htrans", k),  32'(htrans_out), (k <= 3) ? 32'h2 : 32'h0);
      chk($sformatf("k%0d_d_ready", k), 32'(d_ready_out), (k == 7) ? 32'h1 : 32'h0);
    end

    // Reset during a DATA wait state
    tag = "rst_mid";
    step();
    i_req_in  = 1'b1;
    i_addr_in = 32'h0000_0500;
    hready_in = 1'b1;
    #1;
    step(); #1;
    chk("addr_htrans", 32'(htrans_out), 32'h2);
    step();
    hready_in = 1'b0;
    #1;
    chk("wait_i_ready", 32'(i_ready_out), 32'h0);
    #2;
    rst_in    = 1'b1;
    hready_in = 1'b1;
    #1;
    chk("async_htrans",  32'(htrans_out), 32'h0);
    chk("async_haddr",   haddr_out, 32'h0);
    chk("async_i_ready", 32'(i_ready_out), 32'h0);
    step(); #1;
    chk("held_i_ready",  32'(i_ready_out), 32'h0);
    step();
    rst_in = 1'b0;
    #1;
    chk("rel_htrans",  32'(htrans_out), 32'h0);
    step(); #1;
    chk("re_htrans",   32'(htrans_out), 32'h2);
    chk("re_haddr",    haddr_out, 32'h0000_0500);
    chk("re_owner",    32'(owner_out), 32'h0);
    step(); #1;
    chk("re_i_ready",  32'(i_ready_out), 32'h1);
    step();
    i_req_in = 1'b0;
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
